// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush hazard control for an RV32I five-stage pipe: load-use stalls, branch flushes,
// full-pipe freeze on data-memory wait with a sticky timeout trap, and saturating perf counters.
module pipeline_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs_1d,
   input  logic [4:0]       rs_2d,
   input  logic [4:0]       rd_e,
   input  logic             load_e,
   input  logic             pc_src_e,
   input  logic             dmem_req_m,
   input  logic             dmem_ready,
   input  logic             err_ack,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             stall_w,
   output logic             flush_d,
   output logic             flush_e,
   output logic             trap_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TRAP     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              lw_hz;
   logic              mem_hz;

   // A taken branch squashes the D instruction, so a load-use match there needs no stall.
   assign lw_hz  = load_e && (rd_e != 5'd0) && ((rd_e == rs_1d) || (rd_e == rs_2d)) && !pc_src_e;
   assign mem_hz = dmem_req_m && !dmem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state: wait_q counts cycles spent stalled on memory, including the entry cycle.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         RUN: begin
            if (mem_hz) begin
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready || !dmem_req_m) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = TRAP;
               wait_d  = '0;
            end else begin
               wait_d  = WAIT_W'(wait_q + WAIT_W'(1));
            end
         end
         TRAP: begin
            if (err_ack) begin
               state_d = RUN;
               wait_d  = '0;
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   // Hazard outputs: trap beats memory freeze, which beats branch/load-use.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (state_q == TRAP) begin
         {stall_f, stall_d, stall_e, stall_m, stall_w} = 5'b11111;
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (mem_hz) begin
         {stall_f, stall_d, stall_e, stall_m, stall_w} = 5'b11111;
      end else begin
         stall_f = lw_hz;
         stall_d = lw_hz;
         flush_d = pc_src_e;
         flush_e = lw_hz || pc_src_e;
      end
   end

   // Saturating performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_f && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_d && (state_q != TRAP) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   assign trap_o    = (state_q == TRAP);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: stimulus tables push expected output vectors,
// which are popped and compared once the DUT settles each cycle.
module tb_pipeline_stall_ctrl;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       load;
      logic       pc;
      logic       req;
      logic       rdy;
      logic       ack;
      logic [7:0] exp;
   } stim_t;

   // Output vector order: stall_f,d,e,m,w, flush_d, flush_e, trap_o
   localparam logic [7:0] O_IDLE = 8'b00000_00_0;
   localparam logic [7:0] O_LU   = 8'b11000_01_0;
   localparam logic [7:0] O_BR   = 8'b00000_11_0;
   localparam logic [7:0] O_FRZ  = 8'b11111_00_0;
   localparam logic [7:0] O_TRP  = 8'b11111_11_1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_1d, rs_2d, rd_e;
   logic        load_e, pc_src_e, dmem_req_m, dmem_ready, err_ack;
   logic        stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, trap_o;
   logic [31:0] stall_cnt, flush_cnt;
   logic        s4_f, s4_d, s4_e, s4_m, s4_w, f4_d, f4_e, trap4;
   logic [3:0]  stall_cnt4, flush_cnt4;
   logic [7:0]  outs;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   assign outs = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, trap_o};

   pipeline_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rs_1d(rs_1d), .rs_2d(rs_2d), .rd_e(rd_e),
      .load_e(load_e), .pc_src_e(pc_src_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
      .err_ack(err_ack), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
      .trap_o(trap_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .rs_1d(rs_1d), .rs_2d(rs_2d), .rd_e(rd_e),
      .load_e(load_e), .pc_src_e(pc_src_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
      .err_ack(err_ack), .stall_f(s4_f), .stall_d(s4_d), .stall_e(s4_e),
      .stall_m(s4_m), .stall_w(s4_w), .flush_d(f4_d), .flush_e(f4_e),
      .trap_o(trap4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   function automatic stim_t mk(input int rs1, input int rs2, input int rd, input bit load,
                                input bit pc, input bit req, input bit rdy, input bit ack,
                                input logic [7:0] exp);
      stim_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
      s.load = load; s.pc = pc; s.req = req; s.rdy = rdy; s.ack = ack; s.exp = exp;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rs_1d = s.rs1; rs_2d = s.rs2; rd_e = s.rd; load_e = s.load; pc_src_e = s.pc;
      dmem_req_m = s.req; dmem_ready = s.rdy; err_ack = s.ack;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] got, e;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(O_IDLE);
      got = outs; e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", got, e); end
      n_tests++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
      end
      drive(mk(5, 0, 5, 1, 0, 0, 0, 0, O_LU));
      exp_q.push_back(O_LU);
      @(posedge clk);
      #1;
      got = outs; e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL reset_comb got=%b exp=%b", got, e); end
      n_tests++;
      if (stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_hold_cnt got=%0d exp=0", stall_cnt);
      end
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      rst_n = 1'b1;
   endtask

   // Run a table: each cycle pushes the expected vector, then pops it once outputs settle.
   task automatic run_table(input string name, input stim_t t[$]);
      logic [7:0] got, e;
      foreach (t[i]) begin
         @(negedge clk);
         drive(t[i]);
         exp_q.push_back(t[i].exp);
         #1;
         got = outs; e = exp_q.pop_front(); n_tests++;
         if (got !== e) begin
            n_fail++; $display("FAIL %s[%0d] got=%b exp=%b", name, i, got, e);
         end
      end
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      #1;
   endtask

   task automatic test_load_use();
      stim_t t[$];
      do_reset();
      t.push_back(mk(5, 0, 5, 1, 0, 0, 0, 0, O_LU));
      t.push_back(mk(3, 9, 9, 1, 0, 0, 0, 0, O_LU));
      t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(5, 5, 5, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(4, 6, 5, 1, 0, 0, 0, 0, O_IDLE));
      run_table("load_use", t);
      n_tests++;
      if (stall_cnt !== 32'd2 || flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL load_use_cnt got=%0d/%0d exp=2/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_branch_flush();
      stim_t t[$];
      do_reset();
      t.push_back(mk(1, 7, 7, 1, 1, 0, 0, 0, O_BR));
      t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));
      run_table("branch", t);
      n_tests++;
      if (flush_cnt !== 32'd2 || stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL branch_cnt got=%0d/%0d exp=2/0", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      stim_t t[$];
      do_reset();
      t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
      t.push_back(mk(7, 0, 7, 1, 1, 1, 0, 0, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, O_IDLE));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_table("mem_wait", t);
      n_tests++;
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL mem_wait_cnt got=%0d/%0d exp=3/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_timeout_edge();
      stim_t t[$];
      do_reset();
      for (int i = 0; i < 15; i++) t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, O_IDLE));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      t.push_back(mk(2, 0, 2, 1, 0, 0, 0, 0, O_LU));
      run_table("timeout_edge", t);
      n_tests++;
      if (stall_cnt !== 32'd16) begin
         n_fail++; $display("FAIL timeout_edge_cnt got=%0d exp=16", stall_cnt);
      end
   endtask

   task automatic test_trap();
      stim_t t[$];
      do_reset();
      for (int i = 0; i < 16; i++) t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_TRP));
      t.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, O_TRP));
      t.push_back(mk(3, 0, 3, 1, 0, 0, 0, 1, O_TRP));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      run_table("trap", t);
      n_tests++;
      if (stall_cnt !== 32'd19 || flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL trap_cnt got=%0d/%0d exp=19/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_async_reset();
      stim_t t[$];
      logic [7:0] got, e;
      do_reset();
      for (int i = 0; i < 5; i++) t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
      run_table("pre_rst_wait", t);
      drive(mk(5, 0, 5, 1, 0, 0, 0, 0, O_LU));
      rst_n = 1'b0;
      exp_q.push_back(O_LU);
      #1;
      got = outs; e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL rst_wait_outs got=%b exp=%b", got, e); end
      n_tests++;
      if (stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_wait_cnt got=%0d exp=0", stall_cnt);
      end
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      rst_n = 1'b1;
      t.delete();
      for (int i = 0; i < 17; i++) t.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, i < 16 ? O_FRZ : O_TRP));
      run_table("pre_rst_trap", t);
      rst_n = 1'b0;
      exp_q.push_back(O_IDLE);
      #1;
      got = outs; e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL rst_trap_outs got=%b exp=%b", got, e); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      do_reset();
      t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));
      t.push_back(mk(8, 0, 8, 1, 0, 0, 0, 0, O_LU));
      t.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));
      t.push_back(mk(0, 8, 8, 1, 0, 0, 0, 0, O_LU));
      t.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, O_FRZ));
      t.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, O_BR));
      run_table("b2b", t);
      n_tests++;
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd3) begin
         n_fail++; $display("FAIL b2b_cnt got=%0d/%0d exp=3/3", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(mk(6, 0, 6, 1, 0, 0, 0, 0, O_LU));
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(mk(0, 0, 0, 0, 1, 0, 0, 0, O_BR));
      end
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
      #1;
      n_tests++;
      if (stall_cnt4 !== 4'd15 || flush_cnt4 !== 4'd15) begin
         n_fail++; $display("FAIL sat_cnt4 got=%0d/%0d exp=15/15", stall_cnt4, flush_cnt4);
      end
      n_tests++;
      if (stall_cnt !== 32'd20 || flush_cnt !== 32'd20) begin
         n_fail++; $display("FAIL sat_cnt32 got=%0d/%0d exp=20/20", stall_cnt, flush_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_flush();
      test_mem_wait();
      test_timeout_edge();
      test_trap();
      test_async_reset();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
